writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/nand_cpu_pkg.sv | 26 ++
 rtl/writeback_unit_wait_counter.sv | 31 +++
 rtl/writeback_unit.sv | 134 +++++++++++++
 tb/tb_writeback_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_cpu_pkg.sv
// Shared nand_cpu definitions for the writeback unit.
// Provides the writeback FSM state type, the wait-counter width and the control record.
package nand_cpu_pkg;

    // Writeback FSM states.
    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_e;

    // Wide enough for any TIMEOUT in 1..255.
    localparam int WB_CNT_W = 8;

    // Control part of a writeback record.
    typedef struct packed {
        logic use_rw;
        logic write_ps;
    } wb_ctrl_t;

    // Counter value at which the last allowed wait cycle is reached.
    function automatic logic [WB_CNT_W-1:0] wb_last_count(input int timeout);
        return WB_CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/writeback_unit_wait_counter.sv
// Memory-response wait counter for the writeback unit (module wb_wait_counter).
// Ports: clk, rst (sync, active high), i_clr, i_en, o_tc (terminal count reached).
import nand_cpu_pkg::*;

module wb_wait_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [WB_CNT_W-1:0] LAST = wb_last_count(TIMEOUT);

    logic [WB_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            // Saturate at the terminal value; the FSM leaves WAIT_MEM there.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // High during the final permitted wait cycle.
    assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: commits ALU or memory results to the register file.
// Ports: clk, rst, in_* request handshake, mem_rsp_* read data, wb_* registered
// writeback, wb_timeout pulse; fwd_* bypass outputs when WB_FORWARD_EN is defined.
import nand_cpu_pkg::*;

module writeback_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_use_rw,
    input  logic [ADDR_W-1:0] in_rw_addr,
    input  logic              in_write_ps,
    input  logic              in_mem_access,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              wb_valid,
    output logic              wb_use_rw,
    output logic              wb_write_ps,
    output logic              wb_ps,
    output logic [ADDR_W-1:0] wb_rw_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_timeout
`ifdef WB_FORWARD_EN
   ,output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rw_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    wb_state_e         r_state;
    wb_ctrl_t          r_pend_ctrl;
    logic [ADDR_W-1:0] r_pend_addr;
    wb_ctrl_t          r_wb_ctrl;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_valid;
    logic              r_wb_timeout;

    logic     w_ready;
    logic     w_accept;
    logic     w_waiting;
    logic     w_tc;
    wb_ctrl_t w_in_ctrl;

    assign w_waiting = (r_state == WB_WAIT_MEM);
    assign w_ready   = !w_waiting;
    assign w_accept  = in_valid && w_ready;

    assign w_in_ctrl.use_rw   = in_use_rw;
    assign w_in_ctrl.write_ps = in_write_ps;

    wb_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept && in_mem_access),
        .i_en  (w_waiting && !mem_rsp_valid),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WB_IDLE;
            r_pend_ctrl  <= '0;
            r_pend_addr  <= '0;
            r_wb_ctrl    <= '0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_timeout <= 1'b0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_wb_timeout <= 1'b0;
            unique case (r_state)
                WB_IDLE, WB_COMMIT: begin
                    // COMMIT accepts a new request in the same cycle.
                    if (w_accept && !in_mem_access) begin
                        r_state    <= WB_COMMIT;
                        r_wb_valid <= 1'b1;
                        r_wb_ctrl  <= w_in_ctrl;
                        r_wb_addr  <= in_rw_addr;
                        r_wb_data  <= in_alu_data;
                    end else if (w_accept) begin
                        // Any response in this cycle belongs to nobody.
                        r_state     <= WB_WAIT_MEM;
                        r_pend_ctrl <= w_in_ctrl;
                        r_pend_addr <= in_rw_addr;
                    end else begin
                        r_state <= WB_IDLE;
                    end
                end
                WB_WAIT_MEM: begin
                    // A response on the last wait cycle still wins.
                    if (mem_rsp_valid) begin
                        r_state    <= WB_COMMIT;
                        r_wb_valid <= 1'b1;
                        r_wb_ctrl  <= r_pend_ctrl;
                        r_wb_addr  <= r_pend_addr;
                        r_wb_data  <= mem_rsp_data;
                    end else if (w_tc) begin
                        r_state      <= WB_IDLE;
                        r_wb_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WB_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_ready;
    assign wb_valid    = r_wb_valid;
    assign wb_use_rw   = r_wb_valid && r_wb_ctrl.use_rw;
    assign wb_write_ps = r_wb_valid && r_wb_ctrl.write_ps;
    assign wb_ps       = r_wb_data[0];
    assign wb_rw_addr  = r_wb_addr;
    assign wb_data     = r_wb_data;
    assign wb_timeout  = r_wb_timeout;

`ifdef WB_FORWARD_EN
    assign fwd_valid   = wb_valid && wb_use_rw;
    assign fwd_rw_addr = wb_rw_addr;
    assign fwd_data    = wb_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit.
// Expected timing is derived from the accept cycle and response cycle arithmetic.
module tb_writeback_unit;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_use_rw;
    logic [AW-1:0] in_rw_addr;
    logic          in_write_ps;
    logic          in_mem_access;
    logic [DW-1:0] in_alu_data;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          wb_valid;
    logic          wb_use_rw;
    logic          wb_write_ps;
    logic          wb_ps;
    logic [AW-1:0] wb_rw_addr;
    logic [DW-1:0] wb_data;
    logic          wb_timeout;
`ifdef WB_FORWARD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_rw_addr;
    logic [DW-1:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] last_data;

    always #5 clk = ~clk;

    writeback_unit #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_use_rw     (in_use_rw),
        .in_rw_addr    (in_rw_addr),
        .in_write_ps   (in_write_ps),
        .in_mem_access (in_mem_access),
        .in_alu_data   (in_alu_data),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wb_valid      (wb_valid),
        .wb_use_rw     (wb_use_rw),
        .wb_write_ps   (wb_write_ps),
        .wb_ps         (wb_ps),
        .wb_rw_addr    (wb_rw_addr),
        .wb_data       (wb_data),
        .wb_timeout    (wb_timeout)
`ifdef WB_FORWARD_EN
       ,.fwd_valid     (fwd_valid),
        .fwd_rw_addr   (fwd_rw_addr),
        .fwd_data      (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'(wb_valid && wb_use_rw));
        chk("fwd_addr", 32'(fwd_rw_addr), 32'(wb_rw_addr));
        chk("fwd_data", 32'(fwd_data), 32'(wb_data));
`endif
    endtask

    task automatic chk_commit(input string tag, input logic [DW-1:0] d,
                              input logic [AW-1:0] a, input logic u,
                              input logic p);
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "_data"}, 32'(wb_data), 32'(d));
        chk({tag, "_addr"}, 32'(wb_rw_addr), 32'(a));
        chk({tag, "_use"}, 32'(wb_use_rw), 32'(u));
        chk({tag, "_wps"}, 32'(wb_write_ps), 32'(p));
        chk({tag, "_ps"}, 32'(wb_ps), 32'(d[0]));
        last_data = d;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid0"}, 32'(wb_valid), 32'd0);
        chk({tag, "_use0"}, 32'(wb_use_rw), 32'd0);
        chk({tag, "_wps0"}, 32'(wb_write_ps), 32'd0);
        chk({tag, "_tmo0"}, 32'(wb_timeout), 32'd0);
        chk({tag, "_hold"}, 32'(wb_data), 32'(last_data));
    endtask

    task automatic drive_req(input logic mem, input logic [DW-1:0] d,
                             input logic [AW-1:0] a, input logic u,
                             input logic p);
        in_valid      = 1'b1;
        in_mem_access = mem;
        in_alu_data   = d;
        in_rw_addr    = a;
        in_use_rw     = u;
        in_write_ps   = p;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_mem_access = 1'b0;
        in_alu_data   = DW'($urandom);
        in_rw_addr    = AW'($urandom);
        in_use_rw     = 1'($urandom);
        in_write_ps   = 1'($urandom);
    endtask

    task automatic alu_txn(input logic [DW-1:0] d, input logic [AW-1:0] a,
                           input logic u, input logic p);
        drive_req(1'b0, d, a, u, p);
        step();
        idle_inputs();
        chk("alu_rdy", 32'(in_ready), 32'd1);
        chk_commit("alu", d, a, u, p);
        step();
        chk_quiet("alu_after");
    endtask

    // k = wait cycle carrying the response; outside 1..TO means none arrives.
    task automatic mem_txn(input int k, input logic [DW-1:0] d,
                           input logic [AW-1:0] a, input logic u,
                           input logic p);
        bit rsp;
        int e;
        rsp = (k >= 1) && (k <= TO);
        e   = rsp ? k + 1 : TO + 1;
        drive_req(1'b1, ~d, a, u, p);
        mem_rsp_valid = (k == 0);
        mem_rsp_data  = ~d;
        step();
        idle_inputs();
        mem_rsp_valid = 1'b0;
        for (int c = 1; c <= e; c++) begin
            chk("mem_rdy", 32'(in_ready), 32'(c == e));
            chk("mem_valid", 32'(wb_valid), 32'(rsp && c == e));
            chk("mem_tmo", 32'(wb_timeout), 32'(!rsp && c == e));
            if (rsp && c == e) chk_commit("mem", d, a, u, p);
            if (c < e && !rsp) chk("mem_hold", 32'(wb_data), 32'(last_data));
            // A response at cycle e arrives outside WAIT_MEM and is ignored.
            mem_rsp_valid = (c == k) || (c == e);
            mem_rsp_data  = (c == k) ? d : DW'($urandom);
            step();
        end
        mem_rsp_valid = 1'b0;
        chk_quiet("mem_after");
    endtask

    initial begin
        last_data     = '0;
        rst           = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk_quiet("rst");
        chk("rst_addr", 32'(wb_rw_addr), 32'd0);
        chk("rst_ps", 32'(wb_ps), 32'd0);

        // Stray response while idle.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 16'h1234;
        step();
        mem_rsp_valid = 1'b0;
        chk_quiet("stray");

        alu_txn(16'h0003, 3'd5, 1'b1, 1'b0);
        alu_txn(16'h00A4, 3'd2, 1'b0, 1'b1);
        mem_txn(4, 16'hBEEF, 3'd6, 1'b1, 1'b1);
        mem_txn(0, 16'h5555, 3'd1, 1'b1, 1'b0);
        mem_txn(TO, 16'h0F0F, 3'd3, 1'b1, 1'b0);
        mem_txn(1, 16'h8001, 3'd7, 1'b0, 1'b1);

        // Three ALU requests back to back.
        drive_req(1'b0, 16'h1111, 3'd1, 1'b1, 1'b0);
        step();
        chk("b2b_rdy1", 32'(in_ready), 32'd1);
        chk_commit("b2b1", 16'h1111, 3'd1, 1'b1, 1'b0);
        drive_req(1'b0, 16'h2222, 3'd2, 1'b1, 1'b1);
        step();
        chk("b2b_rdy2", 32'(in_ready), 32'd1);
        chk_commit("b2b2", 16'h2222, 3'd2, 1'b1, 1'b1);
        drive_req(1'b0, 16'h3333, 3'd3, 1'b0, 1'b0);
        step();
        chk("b2b_rdy3", 32'(in_ready), 32'd1);
        chk_commit("b2b3", 16'h3333, 3'd3, 1'b0, 1'b0);
        // Memory request accepted straight out of COMMIT.
        mem_txn(3, 16'hC0DE, 3'd4, 1'b1, 1'b1);

        // Reset while waiting, response arrives afterwards.
        drive_req(1'b1, 16'h0000, 3'd5, 1'b1, 1'b1);
        step();
        idle_inputs();
        step();
        step();
        chk("rstw_rdy0", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_data = '0;
        chk("rstw_rdy1", 32'(in_ready), 32'd1);
        chk_quiet("rstw");
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 16'hBEEF;
        step();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < TO + 3; i++) begin
            chk_quiet("rstw_loop");
            step();
        end

        // Randomized mix.
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] d;
            logic [AW-1:0] a;
            d = DW'($urandom);
            a = AW'($urandom);
            if ($urandom_range(0, 1) == 0)
                alu_txn(d, a, 1'($urandom), 1'($urandom));
            else
                mem_txn(int'($urandom_range(0, TO + 2)), d, a,
                        1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
